// File: rtl/decode_stage_pipelined_pkg.sv
// rtl/decode_stage_pipelined_pkg.sv - opcode constants, ex_ctrl bit layout and control decode
package decode_stage_pipelined_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ex_ctrl = {reg_dst, branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write}
  localparam int CTRL_W          = 9;
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_ALU_SRC    = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_ALU_OP_LO  = 3;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_BRANCH     = 7;
  localparam int CTRL_REG_DST    = 8;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] op);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c[CTRL_REG_DST]            = 1'b1;
        c[CTRL_REG_WRITE]          = 1'b1;
        c[CTRL_ALU_OP_LO +: 2]     = ALU_OP_FUNCT;
      end
      OP_LW: begin
        c[CTRL_ALU_SRC]            = 1'b1;
        c[CTRL_MEM_READ]           = 1'b1;
        c[CTRL_MEM_TO_REG]         = 1'b1;
        c[CTRL_REG_WRITE]          = 1'b1;
        c[CTRL_ALU_OP_LO +: 2]     = ALU_OP_ADD;
      end
      OP_SW: begin
        c[CTRL_ALU_SRC]            = 1'b1;
        c[CTRL_MEM_WRITE]          = 1'b1;
        c[CTRL_ALU_OP_LO +: 2]     = ALU_OP_ADD;
      end
      OP_BEQ: begin
        c[CTRL_BRANCH]             = 1'b1;
        c[CTRL_ALU_OP_LO +: 2]     = ALU_OP_SUB;
      end
      OP_ADDI: begin
        c[CTRL_ALU_SRC]            = 1'b1;
        c[CTRL_REG_WRITE]          = 1'b1;
        c[CTRL_ALU_OP_LO +: 2]     = ALU_OP_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_pipelined_regfile_bypass.sv
// rtl/decode_stage_pipelined_regfile_bypass.sv - 2R1W register file, R0 hardwired zero, write-through reads
module regfile_bypass #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Addresses beyond NUM_REGS (non power-of-two sizes) are treated like R0.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(NUM_REGS)) && (a != '0);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && in_range(wr_addr)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (in_range(rs_addr)) rs_data = (we && wr_addr == rs_addr) ? wr_data : regs[rs_addr];
    if (in_range(rt_addr)) rt_data = (we && wr_addr == rt_addr) ? wr_data : regs[rt_addr];
  end

endmodule

// File: rtl/decode_stage_pipelined.sv
// rtl/decode_stage_pipelined.sv - ID stage: regfile, control decode, sign extend, load-use hazard, ID/EX register
module decode_stage_pipelined
  import decode_stage_pipelined_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  int IMM_W    = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       instr,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm_sext,
  output logic [DATA_W-1:0] ex_imm_shl2,
  output logic [IMM_W-1:0]  ex_imm_raw,
  output logic [ADDR_W-1:0] ex_dst_addr,
  output logic [8:0]        ex_ctrl,
  output logic [15:0]       stall_count
);

  logic [5:0]        op;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] rs_data, rt_data, imm_sext;
  logic [CTRL_W-1:0] ctrl;
  logic              uses_rt, hz;

  assign op       = instr[31:26];
  assign rs       = instr[21 +: ADDR_W];
  assign rt       = instr[16 +: ADDR_W];
  assign rd       = instr[11 +: ADDR_W];
  assign imm      = instr[IMM_W-1:0];
  assign ctrl     = decode_ctrl(op);
  assign imm_sext = DATA_W'($signed(imm));

  regfile_bypass #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .rs_addr(rs),
    .rt_addr(rt),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .we     (wb_we),
    .wr_addr(wb_addr),
    .wr_data(wb_data)
  );

  // lw/addi only consume rs; rt is a destination for them, not a source.
  assign uses_rt  = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  assign hz       = if_valid && ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_dst_addr != '0)
                    && ((ex_dst_addr == rs) || ((ex_dst_addr == rt) && uses_rt));
  assign id_ready = !hz || flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm_sext <= '0;
      ex_imm_shl2 <= '0;
      ex_imm_raw  <= '0;
      ex_dst_addr <= '0;
      ex_ctrl     <= '0;
      stall_count <= '0;
    end else begin
      if (flush || hz || !if_valid) begin
        ex_valid    <= 1'b0;
        ex_rs_data  <= '0;
        ex_rt_data  <= '0;
        ex_imm_sext <= '0;
        ex_imm_shl2 <= '0;
        ex_imm_raw  <= '0;
        ex_dst_addr <= '0;
        ex_ctrl     <= '0;
      end else begin
        ex_valid    <= 1'b1;
        ex_rs_data  <= rs_data;
        ex_rt_data  <= rt_data;
        ex_imm_sext <= imm_sext;
        ex_imm_shl2 <= imm_sext << 2;
        ex_imm_raw  <= imm;
        ex_dst_addr <= ctrl[CTRL_REG_DST] ? rd : rt;
        ex_ctrl     <= ctrl;
      end
      if (hz && !flush && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// tb/tb_decode_stage_pipelined.sv - directed and randomized checks of decode_stage_pipelined against a reference model
module tb_decode_stage_pipelined;

  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam int IMM_W = 16;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_valid;
  logic [31:0]       instr;
  logic              flush;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              id_ready;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm_sext, ex_imm_shl2;
  logic [IMM_W-1:0]  ex_imm_raw;
  logic [ADDR_W-1:0] ex_dst_addr;
  logic [8:0]        ex_ctrl;
  logic [15:0]       stall_count;

  always #5 clk = ~clk;

  decode_stage_pipelined #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IMM_W(IMM_W)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .instr(instr), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm_sext(ex_imm_sext), .ex_imm_shl2(ex_imm_shl2), .ex_imm_raw(ex_imm_raw),
    .ex_dst_addr(ex_dst_addr), .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: architectural registers plus what the ID/EX stage should hold.
  int unsigned rf [NUM_REGS];
  logic        m_valid;
  logic [8:0]  m_ctrl;
  logic [31:0] m_rs, m_rt, m_sext, m_shl2;
  logic [15:0] m_raw;
  logic [4:0]  m_dst;
  int          m_stalls;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control word straight from the opcode table, fields in ex_ctrl order.
  function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'd0:    return 9'b1_0_0_0_10_0_0_1;
      6'd35:   return 9'b0_0_1_1_00_0_1_1;
      6'd43:   return 9'b0_0_0_0_00_1_1_0;
      6'd4:    return 9'b0_1_0_0_01_0_0_0;
      6'd8:    return 9'b0_0_0_0_00_0_1_1;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rt, input int rd,
                                     input logic [15:0] imm);
    logic [31:0] w;
    w = {op, rs[4:0], rt[4:0], 16'h0};
    if (op == 6'd0) w[15:0] = {rd[4:0], 11'h020};
    else            w[15:0] = imm;
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) rf[i] = 0;
    m_valid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_sext = 0; m_shl2 = 0;
    m_raw = 0; m_dst = 0; m_stalls = 0;
  endtask

  task automatic check_ex(input string ctx);
    check({ctx, ".ex_valid"},    ex_valid,    m_valid);
    check({ctx, ".ex_ctrl"},     ex_ctrl,     m_ctrl);
    check({ctx, ".ex_rs_data"},  ex_rs_data,  m_rs);
    check({ctx, ".ex_rt_data"},  ex_rt_data,  m_rt);
    check({ctx, ".ex_imm_sext"}, ex_imm_sext, m_sext);
    check({ctx, ".ex_imm_shl2"}, ex_imm_shl2, m_shl2);
    check({ctx, ".ex_imm_raw"},  ex_imm_raw,  m_raw);
    check({ctx, ".ex_dst_addr"}, ex_dst_addr, m_dst);
    check({ctx, ".stall_count"}, stall_count, 64'(m_stalls));
  endtask

  function automatic int unsigned rd_reg(input int a, input logic we, input int wa, input int unsigned wd);
    if (a == 0) return 0;
    if (we && wa == a) return wd;
    return rf[a];
  endfunction

  // One cycle: drive at negedge, check id_ready before the edge, check ID/EX after it.
  task automatic step(input string ctx, input logic iv, input logic [31:0] ins, input logic fl,
                      input logic we, input int wa, input int unsigned wd);
    logic [5:0] op;
    int rs, rt, rd;
    logic uses_rt, hz;
    int unsigned rsv, rtv;
    logic [8:0] c;
    @(negedge clk);
    if_valid = iv; instr = ins; flush = fl; wb_we = we; wb_addr = wa[4:0]; wb_data = wd;
    #1;
    op = ins[31:26]; rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    uses_rt = (op == 6'd0) || (op == 6'd43) || (op == 6'd4);
    hz = iv && m_valid && m_ctrl[6] && m_dst != 0 && (m_dst == rs || (m_dst == rt && uses_rt));
    check({ctx, ".id_ready"}, id_ready, !hz || fl);
    rsv = rd_reg(rs, we, wa, wd);
    rtv = rd_reg(rt, we, wa, wd);
    c = ref_ctrl(op);
    @(posedge clk);
    if (!fl && iv && !hz) begin
      m_valid = 1; m_ctrl = c; m_rs = rsv; m_rt = rtv;
      m_sext = {{16{ins[15]}}, ins[15:0]};
      m_shl2 = m_sext * 4;
      m_raw = ins[15:0];
      m_dst = c[8] ? rd[4:0] : rt[4:0];
    end else begin
      m_valid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_sext = 0; m_shl2 = 0; m_raw = 0; m_dst = 0;
    end
    if (hz && !fl && m_stalls < 65535) m_stalls++;
    if (we && wa != 0) rf[wa] = wd;
    #1;
    check_ex(ctx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; if_valid = 0; instr = 0; flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset.id_ready", id_ready, 1'b1);
    check_ex("reset");
    reset = 0;

    step("r_rs1", 1, mk(6'd0, 1, 0, 4, 0), 0, 0, 0, 0);
    check("r_rs1.rs_zero", ex_rs_data, 32'd0);

    step("bypass", 1, mk(6'd0, 2, 0, 5, 0), 0, 1, 2, 25);
    check("bypass.rs25", ex_rs_data, 32'd25);
    check("bypass.ctrl", ex_ctrl, 9'b100010001);

    step("addi129", 1, mk(6'd8, 2, 6, 0, 16'd129), 0, 0, 0, 0);
    check("addi129.sext", ex_imm_sext, 32'h81);
    check("addi129.shl2", ex_imm_shl2, 32'h204);
    step("addi8001", 1, mk(6'd8, 2, 6, 0, 16'h8001), 0, 0, 0, 0);
    check("addi8001.sext", ex_imm_sext, 32'hFFFF8001);
    check("addi8001.shl2", ex_imm_shl2, 32'hFFFE0004);

    step("lw3", 1, mk(6'd35, 0, 3, 0, 16'd4), 0, 0, 0, 0);
    step("stall", 1, mk(6'd0, 3, 1, 7, 0), 0, 0, 0, 0);
    check("stall.valid", ex_valid, 1'b0);
    check("stall.count", stall_count, 16'd1);
    step("after_stall", 1, mk(6'd0, 3, 1, 7, 0), 0, 0, 0, 0);
    check("after_stall.valid", ex_valid, 1'b1);

    step("lw3b", 1, mk(6'd35, 0, 3, 0, 16'd8), 0, 0, 0, 0);
    step("flush_hz", 1, mk(6'd0, 3, 1, 7, 0), 1, 0, 0, 0);
    check("flush_hz.valid", ex_valid, 1'b0);
    check("flush_hz.count", stall_count, 16'd1);

    step("lw0", 1, mk(6'd35, 1, 0, 0, 16'd0), 0, 0, 0, 0);
    step("use_r0", 1, mk(6'd0, 0, 0, 9, 0), 0, 0, 0, 0);
    check("use_r0.valid", ex_valid, 1'b1);

    step("wr_r0", 1, mk(6'd0, 0, 0, 9, 0), 0, 1, 0, 32'hDEAD);
    step("rd_r0", 1, mk(6'd0, 0, 0, 9, 0), 0, 0, 0, 0);
    check("rd_r0.zero", ex_rs_data, 32'd0);

    step("lw5", 1, mk(6'd35, 0, 5, 0, 16'd0), 0, 0, 0, 0);
    @(negedge clk);
    if_valid = 1; instr = mk(6'd0, 5, 0, 9, 0); flush = 0; wb_we = 0;
    #1;
    check("midstall.id_ready_low", id_ready, 1'b0);
    reset = 1;
    #1;
    check("midstall.valid", ex_valid, 1'b0);
    check("midstall.id_ready", id_ready, 1'b1);
    check("midstall.count", stall_count, 16'd0);
    model_reset();
    @(negedge clk);
    reset = 0;

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      int sel;
      sel = $urandom_range(0, 6);
      case (sel)
        0: op = 6'd0;  1: op = 6'd35; 2: op = 6'd35; 3: op = 6'd43;
        4: op = 6'd4;  5: op = 6'd8;  default: op = 6'($urandom);
      endcase
      step("rand", ($urandom_range(0, 9) != 0), mk(op, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), 16'($urandom)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
